// File: rtl/uart_tx.sv
// RS232 transmitter: ready/valid byte FIFO feeding an 8-bit LSB-first serialiser (8N1).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned FREQ_CLK   = 100000000,
  parameter int unsigned TX_SPEED   = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [7:0]                    Data_In,
  input  logic                          Valid,
  output logic                          Ready,
  output logic                          TXD,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);

  localparam int unsigned BIT_CYCLES = FREQ_CLK / TX_SPEED;
  localparam int unsigned CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW         = PTR_W + 1;
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic             push;
  logic             pop;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign push       = Valid && ready_q;
  assign bit_end    = (baud_q == CNT_W'(BIT_CYCLES - 1));
  assign Ready      = ready_q;
  assign TXD        = txd_q;
  assign Busy       = (state_q != IDLE);
  assign Fifo_Count = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A pop out of a full FIFO reopens Ready only one edge later.
    ready_d = (count_q != FULL) && (count_d != FULL);
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = 1'b1;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        txd_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_d = par_q;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rd_ptr_q];
`endif
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      ready_q  <= 1'b1;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      ready_q  <= ready_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= Data_In;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: random byte stream checked by a line-level serial receiver model.
// Build with UART_TX_PARITY_EN defined to cover the parity frame format.
module tb_uart_tx;

  localparam int unsigned FREQ  = 100;
  localparam int unsigned SPEED = 8;
  localparam int unsigned DEPTH = 4;
  localparam int BC = FREQ / SPEED;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * BC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         frames_rx = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         max_cnt = 0;
  bit         saw_not_ready = 0;

  uart_tx #(.FREQ_CLK(FREQ), .TX_SPEED(SPEED), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(clk), .Rst_n(rst_n), .Data_In(data_in), .Valid(valid),
    .Ready(ready), .TXD(txd), .Busy(busy), .Fifo_Count(fifo_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard helper ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- serial receiver model ----------------
  task automatic rx_period(input logic v, input int n, output bit stable, output bit aborted);
    stable  = 1'b1;
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rst_n) begin
        aborted = 1'b1;
        return;
      end
      if (txd !== v) stable = 1'b0;
    end
  endtask

  initial begin : rx_model
    logic [7:0] byte_v;
    logic [7:0] want;
    logic       b;
    logic       par_bit;
    bit         st, ab;
    byte_v  = '0;
    par_bit = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && txd === 1'b0) begin
        start_q.push_back(cyc);
        rx_period(1'b0, BC - 1, st, ab);
        if (!ab) check("rx_start_stable", 32'(st), 1);
        for (int k = 0; k < 8 && !ab; k++) begin
          @(negedge clk);
          if (!rst_n) ab = 1'b1;
          else begin
            b = txd;
            rx_period(b, BC - 1, st, ab);
            if (!ab) check("rx_data_stable", 32'(st), 1);
            byte_v[k] = b;
          end
        end
`ifdef UART_TX_PARITY_EN
        if (!ab) begin
          @(negedge clk);
          if (!rst_n) ab = 1'b1;
          else begin
            par_bit = txd;
            rx_period(par_bit, BC - 1, st, ab);
            if (!ab) check("rx_parity_stable", 32'(st), 1);
          end
        end
`endif
        if (!ab) begin
          rx_period(1'b1, BC, st, ab);
          if (!ab) check("rx_stop_bit", 32'(st), 1);
        end
        if (!ab) begin
          check("rx_frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("rx_byte", 32'(byte_v), 32'(want));
`ifdef UART_TX_PARITY_EN
            check("rx_parity", 32'(par_bit), 32'($countones(want) % 2));
`endif
          end
          frames_rx++;
        end
      end
    end
  end

  // Ready must stay low for the cycle after a pop from full, then rise.
  initial begin : ready_watch
    logic [2:0] prev_cnt;
    logic       prev_ready;
    bit         chk_rise;
    prev_cnt   = '0;
    prev_ready = 1'b1;
    chk_rise   = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_rise && rst_n) check("ready_rise_after_pop", 32'(ready), 1);
      chk_rise = 1'b0;
      if (rst_n && prev_cnt == 3'(DEPTH) && fifo_count == 3'(DEPTH - 1) && !prev_ready) begin
        check("ready_low_at_pop", 32'(ready), 0);
        chk_rise = 1'b1;
      end
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (!ready) saw_not_ready = 1'b1;
      prev_cnt   = fifo_count;
      prev_ready = ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    data_in = b;
    valid   = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (ready) begin
        exp_q.push_back(b);
        @(negedge clk);
        valid   = 1'b0;
        data_in = 8'($urandom);
        return;
      end
      @(negedge clk);
    end
    check("push_timeout", 32'(ready), 1);
    valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int i;
    i = 0;
    while (frames_rx < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("wait_frames", 32'(frames_rx), 32'(target));
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((busy || fifo_count != 0) && i < 8 * FRAME) begin
      @(negedge clk);
      i++;
    end
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int hi;
    int base;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_txd", 32'(txd), 1);
    check("reset_ready", 32'(ready), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_count", 32'(fifo_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single byte: latency and frame length
    push_byte(8'hAB);
    check("t1_count_after_push", 32'(fifo_count), 1);
    check("t1_busy_before_pop", 32'(busy), 0);
    check("t1_txd_idle", 32'(txd), 1);
    @(negedge clk);
    check("t1_busy_after_pop", 32'(busy), 1);
    check("t1_count_after_pop", 32'(fifo_count), 0);
    check("t1_txd_still_idle", 32'(txd), 1);
    @(negedge clk);
    check("t1_start_latency", 32'(txd), 0);
    hi = 2;
    while (busy && hi < 2 * FRAME) begin
      @(negedge clk);
      if (busy) hi++;
    end
    check("t1_busy_len", 32'(hi), 32'(FRAME));
    wait_frames(1, 4 * FRAME);

    // back-to-back frames without an idle gap
    wait_idle();
    start_q.delete();
    push_byte(8'hAB);
    push_byte(8'hCD);
    wait_frames(3, 4 * FRAME);
    check("t2_two_starts", 32'(start_q.size()), 2);
    if (start_q.size() == 2) check("t2_start_spacing", 32'(start_q[1] - start_q[0]), 32'(FRAME));

    // FIFO fills with Valid held; Ready backpressure
    wait_idle();
    max_cnt = 0;
    saw_not_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    wait_frames(9, 10 * FRAME);
    check("t3_max_count", 32'(max_cnt), 32'(DEPTH));
    check("t3_ready_low_seen", 32'(saw_not_ready), 1);

    // reset in the middle of data bit 3, with bytes still queued
    wait_idle();
    push_byte(8'h55);
    push_byte(8'h11);
    push_byte(8'h22);
    repeat (4 * BC + BC / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_txd", 32'(txd), 1);
    check("t4_busy", 32'(busy), 0);
    check("t4_count", 32'(fifo_count), 0);
    check("t4_ready", 32'(ready), 1);
    exp_q.delete();
    start_q.delete();
    base = frames_rx;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_count_after_release", 32'(fifo_count), 0);
    push_byte(8'h3C);
    wait_frames(base + 1, 4 * FRAME);
    repeat (2 * FRAME) @(negedge clk);
    check("t4_no_stale_frames", 32'(frames_rx), 32'(base + 1));

    // parity-sensitive pair
    wait_idle();
    start_q.delete();
    base = frames_rx;
    push_byte(8'h07);
    push_byte(8'h03);
    wait_frames(base + 2, 4 * FRAME);
    if (start_q.size() == 2) check("t5_frame_len", 32'(start_q[1] - start_q[0]), 32'(FRAME));

    // random stream with random gaps
    base = frames_rx;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, FRAME + 5)) begin
          data_in = 8'($urandom);
          @(negedge clk);
        end
      end
      push_byte(8'($urandom));
    end
    wait_frames(base + 256, 8 * FRAME);
    wait_idle();
    check("final_exp_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
